// File: rtl/riscv_pkg.sv
// Shared core types: word/byte-enable typedefs and the memory arbiter state encoding.
package riscv_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;

    typedef enum logic [1:0] {
        IDLE,
        IMEM,
        DMEM
    } arb_state_t;

    localparam be_t BE_WORD = 4'hF;

    // A full-word access must be word aligned; partial byte-enable accesses may sit anywhere.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb, input be_t be);
        return (addr_lsb != 2'b00) && (be == BE_WORD);
    endfunction

endpackage

// File: rtl/bus_timeout.sv
// Bus acknowledge watchdog: counts stalled request cycles and flags expiry; TIMEOUT=0 disables it.
module bus_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;

    // Expiry is flagged in the cycle whose stall would bring the count to TIMEOUT.
    assign expired = (TIMEOUT != 0) && count_en && (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data port arbiter onto one shared bus, one transaction outstanding at a time.
// Define ARB_ROUND_ROBIN_EN to break simultaneous requests by last owner instead of fixed dmem priority.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  imem_req,
    input  word_t imem_addr,
    output logic  imem_gnt,
    output logic  imem_rvalid,
    output logic  imem_error,
    output word_t imem_rdata,
    input  logic  dmem_req,
    input  logic  dmem_we,
    input  be_t   dmem_be,
    input  word_t dmem_addr,
    input  word_t dmem_wdata,
    output logic  dmem_gnt,
    output logic  dmem_rvalid,
    output logic  dmem_error,
    output word_t dmem_rdata,
    output logic  bus_req,
    output logic  bus_we,
    output be_t   bus_be,
    output word_t bus_addr,
    output word_t bus_wdata,
    input  logic  bus_ack,
    input  logic  bus_err,
    input  word_t bus_rdata
);

    arb_state_t state, state_next;
    logic       i_mis, d_mis, expired, done, tie_to_dmem;

    assign i_mis = is_misaligned(imem_addr[1:0], BE_WORD);
    assign d_mis = is_misaligned(dmem_addr[1:0], dmem_be);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dmem;
    assign tie_to_dmem = !last_dmem;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_dmem <= 1'b0;
        end else if (imem_gnt || dmem_gnt) begin
            last_dmem <= dmem_gnt;
        end
    end
`else
    assign tie_to_dmem = 1'b1;
`endif

    // Misaligned accesses are granted but never leave IDLE; their error response is produced directly.
    always_comb begin
        state_next = state;
        imem_gnt   = 1'b0;
        dmem_gnt   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (dmem_req && (!imem_req || tie_to_dmem)) begin
                    dmem_gnt = 1'b1;
                    if (!d_mis) state_next = DMEM;
                end else if (imem_req) begin
                    imem_gnt = 1'b1;
                    if (!i_mis) state_next = IMEM;
                end
            end
            IMEM, DMEM: begin
                if (bus_ack || expired) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (imem_gnt || dmem_gnt),
        .count_en(bus_req && !bus_ack),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_be      <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            imem_rvalid <= 1'b0;
            imem_error  <= 1'b0;
            imem_rdata  <= '0;
            dmem_rvalid <= 1'b0;
            dmem_error  <= 1'b0;
            dmem_rdata  <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            imem_error  <= 1'b0;
            dmem_rvalid <= 1'b0;
            dmem_error  <= 1'b0;
            if (dmem_gnt) begin
                if (d_mis) begin
                    dmem_rvalid <= 1'b1;
                    dmem_error  <= 1'b1;
                    dmem_rdata  <= '0;
                end else begin
                    bus_req   <= 1'b1;
                    bus_we    <= dmem_we;
                    bus_be    <= dmem_be;
                    bus_addr  <= dmem_addr;
                    bus_wdata <= dmem_wdata;
                end
            end else if (imem_gnt) begin
                if (i_mis) begin
                    imem_rvalid <= 1'b1;
                    imem_error  <= 1'b1;
                    imem_rdata  <= '0;
                end else begin
                    bus_req   <= 1'b1;
                    bus_we    <= 1'b0;
                    bus_be    <= BE_WORD;
                    bus_addr  <= imem_addr;
                    bus_wdata <= '0;
                end
            end
            // An ack in the expiry cycle still wins and returns the bus's own data and error.
            if (done) begin
                bus_req <= 1'b0;
                if (state == IMEM) begin
                    imem_rvalid <= 1'b1;
                    imem_error  <= bus_ack ? bus_err : 1'b1;
                    imem_rdata  <= bus_ack ? bus_rdata : '0;
                end else begin
                    dmem_rvalid <= 1'b1;
                    dmem_error  <= bus_ack ? bus_err : 1'b1;
                    dmem_rdata  <= bus_ack ? bus_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants, bus activity and responses.
module tb_mem_arbiter;
    import riscv_pkg::*;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic  err;
        word_t rdata;
        int    cyc;
    } rsp_t;

    logic  clk = 1'b0, reset = 1'b1;
    logic  imem_req = 1'b0, imem_gnt, imem_rvalid, imem_error;
    word_t imem_addr = '0, imem_rdata;
    logic  dmem_req = 1'b0, dmem_we = 1'b0, dmem_gnt, dmem_rvalid, dmem_error;
    be_t   dmem_be = '0;
    word_t dmem_addr = '0, dmem_wdata = '0, dmem_rdata;
    logic  bus_req, bus_we, bus_ack = 1'b0, bus_err = 1'b0;
    be_t   bus_be;
    word_t bus_addr, bus_wdata, bus_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_error(imem_error), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    int    nvec = 0, nerr = 0, cyc = 0;
    rsp_t  iq[$], dq[$];
    rsp_t  ri, rd;
    word_t last_i = '0, last_d = '0;
    logic  mon_en = 1'b0;

    // expected per-cycle view, written by the stimulus side
    logic  exp_ignt = 0, exp_dgnt = 0, exp_breq = 0, exp_bwe = 0, exp_bdm = 0;
    be_t   exp_bbe = '0;
    word_t exp_baddr = '0, exp_bwdata = '0;

    // reference model: owner (0 none, 1 imem, 2 dmem), stalled cycles, chosen ack delay
    int    m_busy = 0, m_wait = 0, m_d = 0;
    word_t m_rdata = '0;
    logic  m_err = 0, m_last_d = 0;
    int    nxt_delay = 1;
    word_t nxt_rdata = '0;
    logic  nxt_err = 0, spur = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: compares the DUT against the model's expectations every cycle
    initial forever begin
        @(negedge clk);
        if (reset) begin
            last_i = '0;
            last_d = '0;
        end else if (mon_en) begin
            chk("imem_gnt", 32'(imem_gnt), 32'(exp_ignt));
            chk("dmem_gnt", 32'(dmem_gnt), 32'(exp_dgnt));
            chk("bus_req", 32'(bus_req), 32'(exp_breq));
            if (exp_breq) begin
                chk("bus_addr", bus_addr, exp_baddr);
                chk("bus_we", 32'(bus_we), 32'(exp_bwe));
                chk("bus_be", 32'(bus_be), 32'(exp_bbe));
                if (exp_bdm) chk("bus_wdata", bus_wdata, exp_bwdata);
            end
            if (imem_rvalid) begin
                if (iq.size() == 0) chk("imem_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    ri = iq.pop_front();
                    chk("imem_rvalid_cycle", cyc, ri.cyc);
                    chk("imem_error", 32'(imem_error), 32'(ri.err));
                    chk("imem_rdata", imem_rdata, ri.rdata);
                    last_i = ri.rdata;
                end
            end else begin
                chk("imem_rdata_hold", imem_rdata, last_i);
                if (iq.size() != 0 && iq[0].cyc <= cyc) begin
                    chk("imem_rvalid_missing", 32'd0, 32'd1);
                    void'(iq.pop_front());
                end
            end
            if (dmem_rvalid) begin
                if (dq.size() == 0) chk("dmem_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    rd = dq.pop_front();
                    chk("dmem_rvalid_cycle", cyc, rd.cyc);
                    chk("dmem_error", 32'(dmem_error), 32'(rd.err));
                    chk("dmem_rdata", dmem_rdata, rd.rdata);
                    last_d = rd.rdata;
                end
            end else begin
                chk("dmem_rdata_hold", dmem_rdata, last_d);
                if (dq.size() != 0 && dq[0].cyc <= cyc) begin
                    chk("dmem_rvalid_missing", 32'd0, 32'd1);
                    void'(dq.pop_front());
                end
            end
        end
    end

    task automatic push_rsp(input int owner, input logic err, input word_t rdata);
        if (owner == 1) iq.push_back('{err, rdata, cyc + 1});
        else            dq.push_back('{err, rdata, cyc + 1});
    endtask

    // one clock of stimulus plus the model's view of what that cycle must do
    task automatic step(input logic ir, input word_t ia, input logic dr, input logic dw,
                        input be_t db, input word_t da, input word_t dd, input logic rst);
        int g;
        @(posedge clk);
        #1;
        reset = rst;
        imem_req = ir; imem_addr = ia;
        dmem_req = dr; dmem_we = dw; dmem_be = db; dmem_addr = da; dmem_wdata = dd;
        exp_ignt = 0; exp_dgnt = 0;
        exp_breq = (m_busy != 0);
        bus_ack = 1'b0; bus_err = 1'($urandom); bus_rdata = $urandom;
        g = 0;
        if (rst) begin
            m_busy = 0; m_last_d = 0;
        end else if (m_busy == 0) begin
            bus_ack = spur | ($urandom_range(0, 3) == 0);
            if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
                g = m_last_d ? 1 : 2;
`else
                g = 2;
`endif
            end else if (dr) g = 2;
            else if (ir) g = 1;
            exp_ignt = (g == 1); exp_dgnt = (g == 2);
            if (g != 0) m_last_d = (g == 2);
            if ((g == 1 && ia[1:0] != 2'b00) || (g == 2 && da[1:0] != 2'b00 && db == 4'hF)) begin
                push_rsp(g, 1'b1, '0);
            end else if (g != 0) begin
                m_busy = g; m_wait = 0; m_d = nxt_delay; m_rdata = nxt_rdata; m_err = nxt_err;
                exp_bdm    = (g == 2);
                exp_bwe    = (g == 2) ? dw : 1'b0;
                exp_bbe    = (g == 2) ? db : 4'hF;
                exp_baddr  = (g == 2) ? da : ia;
                exp_bwdata = dd;
            end
        end else begin
            if (m_wait == m_d) begin
                bus_ack = 1'b1; bus_rdata = m_rdata; bus_err = m_err;
                push_rsp(m_busy, m_err, m_rdata);
                m_busy = 0;
            end else if (TIMEOUT != 0 && m_wait + 1 == TIMEOUT) begin
                push_rsp(m_busy, 1'b1, '0);
                m_busy = 0;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, 0, 0, '0, '0, '0, 0);
    endtask

    initial begin
        word_t ia, da;
        be_t   db;
        int    r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_gnt", 32'(imem_gnt), 0);
        chk("rst_dmem_gnt", 32'(dmem_gnt), 0);
        chk("rst_imem_rvalid", 32'(imem_rvalid), 0);
        chk("rst_dmem_rvalid", 32'(dmem_rvalid), 0);
        chk("rst_imem_error", 32'(imem_error), 0);
        chk("rst_dmem_error", 32'(dmem_error), 0);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_we", 32'(bus_we), 0);
        chk("rst_bus_be", 32'(bus_be), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_imem_rdata", imem_rdata, 0);
        chk("rst_dmem_rdata", dmem_rdata, 0);
        mon_en = 1'b1;

        // fetch with ack two cycles after the bus request
        nxt_delay = 2; nxt_rdata = 32'h0000_0013; nxt_err = 0;
        step(1, 32'h100, 0, 0, '0, '0, '0, 0);
        idle(5);

        // both requesters held: tie resolution repeated
        for (int k = 0; k < 8; k++) begin
            nxt_delay = 0; nxt_rdata = $urandom; nxt_err = 0;
            step(1, 32'h400 + 32'(k * 4), 1, 0, 4'hF, 32'h800 + 32'(k * 4), '0, 0);
        end
        idle(3);

        // write that is never acknowledged
        nxt_delay = 1000;
        step(0, '0, 1, 1, 4'hF, 32'h2000, 32'hDEAD_BEEF, 0);
        idle(20);

        // ack coinciding with expiry, then ack one cycle too late
        nxt_delay = TIMEOUT - 1; nxt_rdata = 32'h5A5A_0001; nxt_err = 0;
        step(0, '0, 1, 0, 4'hF, 32'h3000, '0, 0);
        idle(20);
        nxt_delay = TIMEOUT;
        step(1, 32'h3004, 0, 0, '0, '0, '0, 0);
        idle(20);

        // misaligned word accesses on both ports; partial-word unaligned goes to the bus
        step(0, '0, 1, 0, 4'hF, 32'h1002, '0, 0);
        idle(2);
        step(1, 32'h0000_0101, 0, 0, '0, '0, '0, 0);
        idle(2);
        nxt_delay = 0; nxt_rdata = 32'h0000_00AB;
        step(0, '0, 1, 0, 4'h4, 32'h1002, '0, 0);
        idle(3);

        // reset in the middle of a data transaction, late ack, then a normal fetch
        nxt_delay = 1000;
        step(0, '0, 1, 1, 4'h3, 32'h4000, 32'h1234_5678, 0);
        idle(3);
        step(0, '0, 0, 0, '0, '0, '0, 1);
        spur = 1;
        idle(1);
        spur = 0;
        nxt_delay = 1; nxt_rdata = 32'hCAFE_0001; nxt_err = 0;
        step(1, 32'h200, 0, 0, '0, '0, '0, 0);
        idle(4);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      nxt_delay = $urandom_range(0, 3);
            else if (r < 8) nxt_delay = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
            else            nxt_delay = 1000;
            nxt_rdata = $urandom; nxt_err = ($urandom_range(0, 4) == 0);
            ia = $urandom & 32'hFFFF_FFFC;
            da = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) ia = ia | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) da = da | 32'($urandom_range(1, 3));
            db = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            step(1'($urandom), ia, 1'($urandom), 1'($urandom), db, da, $urandom, 0);
        end

        for (int k = 0; k < 100 && m_busy != 0; k++) idle(1);
        idle(3);
        chk("model_drained", 32'(m_busy), 0);
        chk("imem_queue_empty", 32'(iq.size()), 0);
        chk("dmem_queue_empty", 32'(dq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
